regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (w_en/rd/din) among three writeback requesters: debug/loader port, memory-load writeback and ALU writeback.
- Each requester uses a valid/ready handshake. The winner is registered onto the write port one cycle later.
- Writes to x0 are accepted and discarded, so the register file never sees them.
- Provides an ALU anti-starvation override and a saturating collision counter for performance monitoring.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/prio_grant3.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared requester indices and register-file widths.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int REQ_DBG   = 0;
    localparam int REQ_MEM   = 1;
    localparam int REQ_ALU   = 2;
    localparam int NUM_REQ   = 3;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // True when two or more bits of a 3-bit request vector are set
    function automatic logic multi_req(input logic [NUM_REQ-1:0] req);
        return (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_grant3.sv
`default_nettype none
// ============================================================================
// Module      : prio_grant3
// Description : 3-input one-hot priority encoder; swap exchanges ranks 1/2.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_grant3
    import rv_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               swap,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[0]) begin
            gnt[0] = 1'b1;
        end else if (swap) begin
            if (req[2])      gnt[2] = 1'b1;
            else if (req[1]) gnt[1] = 1'b1;
        end else begin
            if (req[1])      gnt[1] = 1'b1;
            else if (req[2]) gnt[2] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates DBG/MEM/ALU writebacks onto one register-file port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int m          = RF_ADDR_W,
    parameter int n          = RF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dbg_valid,
    output logic         dbg_ready,
    input  logic [m-1:0] dbg_rd,
    input  logic [n-1:0] dbg_data,
    input  logic         mem_valid,
    output logic         mem_ready,
    input  logic [m-1:0] mem_rd,
    input  logic [n-1:0] mem_data,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [m-1:0] alu_rd,
    input  logic [n-1:0] alu_data,
    output logic         w_en,
    output logic [m-1:0] rd,
    output logic [n-1:0] din,
    output logic [15:0]  collisions
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0]         r_sc;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_starved;
    logic               w_xfer;
    logic [m-1:0]       w_win_rd;
    logic [n-1:0]       w_win_data;

    assign w_req     = {alu_valid, mem_valid, dbg_valid};
    assign w_starved = (r_sc == c_starve_max);

    prio_grant3 u_prio (
        .req  (w_req),
        .swap (w_starved),
        .gnt  (w_gnt)
    );

    // Readys are masked while reset is held so nothing is accepted then
    assign dbg_ready = w_gnt[REQ_DBG] & ~rst;
    assign mem_ready = w_gnt[REQ_MEM] & ~rst;
    assign alu_ready = w_gnt[REQ_ALU] & ~rst;
    assign w_xfer    = dbg_ready | mem_ready | alu_ready;

    always_comb begin
        w_win_rd   = alu_rd;
        w_win_data = alu_data;
        if (w_gnt[REQ_DBG]) begin
            w_win_rd   = dbg_rd;
            w_win_data = dbg_data;
        end else if (w_gnt[REQ_MEM]) begin
            w_win_rd   = mem_rd;
            w_win_data = mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc <= '0;
        end else if (alu_valid && !alu_ready) begin
            if (!w_starved) r_sc <= r_sc + 4'd1;
        end else begin
            r_sc <= '0;
        end
    end

    // x0 writes complete the handshake but never reach the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en <= 1'b0;
            rd   <= '0;
            din  <= '0;
        end else if (w_xfer && (w_win_rd != '0)) begin
            w_en <= 1'b1;
            rd   <= w_win_rd;
            din  <= w_win_data;
        end else begin
            w_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collisions <= '0;
        end else if (multi_req(w_req) && (collisions != 16'hFFFF)) begin
            collisions <= collisions + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed scoreboard bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_valid, mem_valid, alu_valid;
    logic        dbg_ready, mem_ready, alu_ready;
    logic [4:0]  dbg_rd, mem_rd, alu_rd;
    logic [31:0] dbg_data, mem_data, alu_data;
    logic        w_en;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [15:0] collisions;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.m(5), .n(32), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_rd     (dbg_rd),
        .dbg_data   (dbg_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .w_en       (w_en),
        .rd         (rd),
        .din        (din),
        .collisions (collisions)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [4:0] dr, input logic [31:0] dd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        dbg_valid = dv; dbg_rd = dr; dbg_data = dd;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        alu_valid = av; alu_rd = ar; alu_data = ad;
    endtask

    // Compare the write port with the oldest scoreboard entry
    task automatic check_write(input string tag);
        wr_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_wen"}, {31'd0, w_en}, {31'd0, e.en});
            if (e.en) begin
                chk({tag, "_rd"},  {27'd0, rd}, {27'd0, e.rd});
                chk({tag, "_din"}, din, e.data);
            end
        end
    endtask

    // exp_gnt is {alu, mem, dbg}; the expected write follows from it
    task automatic push_expect(input logic [2:0] exp_gnt);
        wr_t e;
        e = '0;
        if (exp_gnt[0])      e = '{en: (dbg_rd != 0), rd: dbg_rd, data: dbg_data};
        else if (exp_gnt[1]) e = '{en: (mem_rd != 0), rd: mem_rd, data: mem_data};
        else if (exp_gnt[2]) e = '{en: (alu_rd != 0), rd: alu_rd, data: alu_data};
        sb_q.push_back(e);
    endtask

    // Caller is just past a posedge; inputs already driven
    task automatic step(input string tag, input logic [2:0] exp_gnt);
        @(negedge clk);
        chk({tag, "_ready"}, {29'd0, alu_ready, mem_ready, dbg_ready}, {29'd0, exp_gnt});
        check_write(tag);
        push_expect(exp_gnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h4);
        #2;
        chk("rst_wen",  {31'd0, w_en}, 32'd0);
        chk("rst_rd",   {27'd0, rd}, 32'd0);
        chk("rst_din",  din, 32'd0);
        chk("rst_coll", {16'd0, collisions}, 32'd0);
        chk("rst_ready", {29'd0, alu_ready, mem_ready, dbg_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('0);

        drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'h0000_0005);
        step("alu_single", 3'b100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle1", 3'b000);
        chk("coll_zero", {16'd0, collisions}, 32'd0);

        drive(0, 0, 0, 1, 5'd7, 32'h13, 1, 5'd6, 32'h1);
        step("mem_vs_alu", 3'b010);
        drive(0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h1);
        step("alu_after_mem", 3'b100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle2", 3'b000);
        chk("coll_one", {16'd0, collisions}, 32'd1);

        // ALU starved by continuous MEM traffic
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 5'd8, 32'h100 + 32'(i), 1, 5'd9, 32'h99);
            step($sformatf("starve_deny%0d", i), 3'b010);
        end
        drive(0, 0, 0, 1, 5'd8, 32'h200, 1, 5'd9, 32'h99);
        step("starve_alu_win", 3'b100);
        drive(0, 0, 0, 1, 5'd8, 32'h201, 1, 5'd9, 32'h9A);
        step("starve_mem_again", 3'b010);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 5'd8, 32'h300 + 32'(i), 1, 5'd9, 32'h9A);
            step($sformatf("restarve%0d", i), 3'b010);
        end
        drive(1, 5'd10, 32'hAA, 1, 5'd8, 32'h400, 1, 5'd9, 32'h9A);
        step("dbg_over_starved", 3'b001);
        drive(0, 0, 0, 1, 5'd8, 32'h400, 1, 5'd9, 32'h9A);
        step("alu_after_dbg", 3'b100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle3", 3'b000);
        chk("coll_twelve", {16'd0, collisions}, 32'd12);

        drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF);
        step("alu_x0", 3'b100);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle4", 3'b000);

        drive(0, 0, 0, 1, 5'd3, 32'h33, 0, 0, 0);
        step("mem_pre_rst", 3'b010);
        // Write is now on the port; reset hits mid-cycle with MEM pending
        drive(0, 0, 0, 1, 5'd3, 32'h303, 0, 0, 0);
        check_write("wen_before_rst");
        rst = 1'b1;
        #1;
        chk("async_wen",  {31'd0, w_en}, 32'd0);
        chk("async_rd",   {27'd0, rd}, 32'd0);
        chk("async_din",  din, 32'd0);
        chk("async_coll", {16'd0, collisions}, 32'd0);
        chk("async_ready", {29'd0, alu_ready, mem_ready, dbg_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_wen", {31'd0, w_en}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {29'd0, alu_ready, mem_ready, dbg_ready}, 32'b010);
        push_expect(3'b010);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_write("post_rst_write");
        chk("post_rst_coll", {16'd0, collisions}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
